// File: rtl/io_bank_arbiter_if.sv
// rtl/io_bank_arbiter_if.sv - requester and bank signal bundle for io_bank_arbiter
interface io_bank_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              i_req0;
    logic [ADDR_W-1:0] i_addr0;
    logic              i_we0;
    logic [DATA_W-1:0] i_wdata0;
    logic [2:0]        i_funct0;
    logic              i_req1;
    logic [ADDR_W-1:0] i_addr1;
    logic              i_we1;
    logic [DATA_W-1:0] i_wdata1;
    logic [2:0]        i_funct1;
    logic              o_ack0;
    logic              o_ack1;
    logic              o_err0;
    logic              o_err1;
    logic [DATA_W-1:0] o_rdata;
    logic              o_bank_en;
    logic              o_bank_we;
    logic [ADDR_W-1:0] o_bank_addr;
    logic [DATA_W-1:0] o_bank_wdata;
    logic [2:0]        o_bank_funct;
    logic [DATA_W-1:0] i_bank_rdata;

    // Arbiter side
    modport slave (
        input  i_req0, i_addr0, i_we0, i_wdata0, i_funct0,
        input  i_req1, i_addr1, i_we1, i_wdata1, i_funct1,
        output o_ack0, o_ack1, o_err0, o_err1, o_rdata,
        output o_bank_en, o_bank_we, o_bank_addr, o_bank_wdata, o_bank_funct,
        input  i_bank_rdata
    );

    // Requesters and bank side
    modport master (
        output i_req0, i_addr0, i_we0, i_wdata0, i_funct0,
        output i_req1, i_addr1, i_we1, i_wdata1, i_funct1,
        input  o_ack0, o_ack1, o_err0, o_err1, o_rdata,
        input  o_bank_en, o_bank_we, o_bank_addr, o_bank_wdata, o_bank_funct,
        output i_bank_rdata
    );
endinterface

// File: rtl/io_bank_arbiter.sv
// rtl/io_bank_arbiter.sv - two-port round-robin arbiter and sequencer for the output peripheral bank
module io_bank_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    io_bank_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] BANK_SIZE = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [2:0]        lat_funct;
    logic              lat_id;
    logic              last_win;
    logic [DATA_W-1:0] rdata_q;

    logic              grant_any;
    logic              grant_id;
    logic [ADDR_W:0]   acc_size;
    logic [ADDR_W:0]   acc_end;
    logic              funct_ok;
    logic              legal;

    logic              bank_en;
    logic              ack0;
    logic              ack1;
    logic              err0;
    logic              err1;

    // Winner selection: a lone request wins; on a tie the port that lost last time wins
    always_comb begin
        grant_any = bus.i_req0 | bus.i_req1;
        grant_id  = bus.i_req1 & (~bus.i_req0 | ~last_win);
    end

    // Access size and bounds check on the latched payload, one extra bit so no wrap-around
    always_comb begin
        acc_size = '0;
        funct_ok = 1'b1;
        case (lat_funct)
            3'd0, 3'd4: acc_size = {{ADDR_W{1'b0}}, 1'b1};
            3'd1, 3'd5: acc_size = {{(ADDR_W-1){1'b0}}, 2'b10};
            3'd2:       acc_size = {{(ADDR_W-2){1'b0}}, 3'b100};
            default:    funct_ok = 1'b0;
        endcase
        acc_end = {1'b0, lat_addr} + acc_size;
        legal   = funct_ok && (acc_end <= BANK_SIZE);
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state strobes
    always_comb begin
        state_nxt = state;
        bank_en   = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                bank_en   = legal;
                state_nxt = DONE;
            end
            DONE: begin
                ack0      = ~lat_id;
                ack1      = lat_id;
                err0      = ~lat_id & ~legal;
                err1      = lat_id & ~legal;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winning transaction when leaving IDLE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_funct <= '0;
            lat_id    <= 1'b0;
        end else if (state == IDLE && grant_any) begin
            lat_id    <= grant_id;
            lat_addr  <= grant_id ? bus.i_addr1  : bus.i_addr0;
            lat_we    <= grant_id ? bus.i_we1    : bus.i_we0;
            lat_wdata <= grant_id ? bus.i_wdata1 : bus.i_wdata0;
            lat_funct <= grant_id ? bus.i_funct1 : bus.i_funct0;
        end
    end

    // Capture load data at the end of ACCESS; stores and rejected accesses return zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (state == ACCESS) begin
            rdata_q <= (legal && !lat_we) ? bus.i_bank_rdata : '0;
        end
    end

    // Round-robin pointer remembers the last completed winner; reset favours port 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_win <= 1'b1;
        end else if (state == DONE) begin
            last_win <= lat_id;
        end
    end

    assign bus.o_ack0        = ack0;
    assign bus.o_ack1        = ack1;
    assign bus.o_err0        = err0;
    assign bus.o_err1        = err1;
    assign bus.o_rdata       = rdata_q;
    assign bus.o_bank_en     = bank_en;
    assign bus.o_bank_we     = lat_we & bank_en;
    assign bus.o_bank_addr   = lat_addr;
    assign bus.o_bank_wdata  = lat_wdata;
    assign bus.o_bank_funct  = lat_funct;
endmodule

// File: tb/tb_io_bank_arbiter.sv
// tb/tb_io_bank_arbiter.sv - self-checking bench for io_bank_arbiter
module tb_io_bank_arbiter;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef struct {
        logic        port;
        logic        we;
        logic [5:0]  addr;
        logic [2:0]  funct;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct packed {
        logic        id;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    io_bank_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    io_bank_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Behavioural peripheral bank: little-endian bytes, sign extension by funct
    logic [7:0]  mem [64];
    logic [5:0]  a0, a1, a2, a3;
    logic [31:0] bank_rd;
    assign a0 = bus.o_bank_addr;
    assign a1 = a0 + 6'd1;
    assign a2 = a0 + 6'd2;
    assign a3 = a0 + 6'd3;

    always @(posedge clk) begin
        if (bus.o_bank_en && bus.o_bank_we) begin
            mem[a0] <= bus.o_bank_wdata[7:0];
            if (bus.o_bank_funct[1:0] != 2'd0) mem[a1] <= bus.o_bank_wdata[15:8];
            if (bus.o_bank_funct[1:0] == 2'd2) begin
                mem[a2] <= bus.o_bank_wdata[23:16];
                mem[a3] <= bus.o_bank_wdata[31:24];
            end
        end
    end

    always_comb begin
        bank_rd = 32'hDEADBEEF;
        if (bus.o_bank_en) begin
            case (bus.o_bank_funct)
                3'd0:    bank_rd = {{24{mem[a0][7]}}, mem[a0]};
                3'd4:    bank_rd = {24'd0, mem[a0]};
                3'd1:    bank_rd = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
                3'd5:    bank_rd = {16'd0, mem[a1], mem[a0]};
                3'd2:    bank_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};
                default: bank_rd = 32'hDEADBEEF;
            endcase
        end
    end
    assign bus.i_bank_rdata = bank_rd;

    // Scoreboard: every ack pops the oldest expected completion
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.o_ack0 || bus.o_ack1)) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_ack", {30'd0, bus.o_ack1, bus.o_ack0}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_ack_id", 32'(bus.o_ack1), 32'(e.id));
                check("sb_dual_ack", 32'(bus.o_ack0 & bus.o_ack1), 32'd0);
                check("sb_err", 32'(e.id ? bus.o_err1 : bus.o_err0), 32'(e.err));
                check("sb_other_err", 32'(e.id ? bus.o_err0 : bus.o_err1), 32'd0);
                check("sb_rdata", bus.o_rdata, e.rdata);
            end
        end
    end

    function automatic vec_t mk(logic p, logic we, logic [5:0] a, logic [2:0] f,
                                logic [31:0] wd, logic e, logic [31:0] rd);
        vec_t v;
        v.port = p; v.we = we; v.addr = a; v.funct = f;
        v.wdata = wd; v.err = e; v.rdata = rd;
        return v;
    endfunction

    function automatic exp_t mke(logic id, logic e, logic [31:0] rd);
        exp_t x;
        x.id = id; x.err = e; x.rdata = rd;
        return x;
    endfunction

    task automatic drive_port(input logic p, input logic req, input logic we,
                              input logic [5:0] a, input logic [2:0] f, input logic [31:0] wd);
        if (p == 1'b0) begin
            bus.i_req0 = req; bus.i_we0 = we; bus.i_addr0 = a; bus.i_funct0 = f; bus.i_wdata0 = wd;
        end else begin
            bus.i_req1 = req; bus.i_we1 = we; bus.i_addr1 = a; bus.i_funct1 = f; bus.i_wdata1 = wd;
        end
    endtask

    // One transaction from an idle arbiter; called on a falling edge
    task automatic do_txn(input string nm, input vec_t v);
        drive_port(v.port, 1'b1, v.we, v.addr, v.funct, v.wdata);
        exp_q.push_back(mke(v.port, v.err, v.rdata));
        @(negedge clk);
        // payload only needs to be valid on the sampling edge
        drive_port(v.port, 1'b1, ~v.we, 6'($urandom), 3'($urandom), $urandom);
        check({nm, "_en"}, 32'(bus.o_bank_en), 32'(!v.err));
        check({nm, "_we"}, 32'(bus.o_bank_we), 32'(v.we & !v.err));
        check({nm, "_addr"}, 32'(bus.o_bank_addr), 32'(v.addr));
        @(negedge clk);
        check({nm, "_ack"}, 32'(v.port ? bus.o_ack1 : bus.o_ack0), 32'd1);
        check({nm, "_en_done"}, 32'(bus.o_bank_en), 32'd0);
        drive_port(v.port, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int c0, c1, cyc, last_ack;
        vecs[0]  = mk(1'b0, 1'b1, 6'd48, 3'd2, 32'h12345678, 1'b0, 32'h00000000);
        vecs[1]  = mk(1'b0, 1'b0, 6'd48, 3'd2, 32'h00000000, 1'b0, 32'h12345678);
        vecs[2]  = mk(1'b1, 1'b1, 6'd32, 3'd0, 32'hAAAAAA80, 1'b0, 32'h00000000);
        vecs[3]  = mk(1'b1, 1'b0, 6'd32, 3'd0, 32'h00000000, 1'b0, 32'hFFFFFF80);
        vecs[4]  = mk(1'b1, 1'b0, 6'd32, 3'd4, 32'h00000000, 1'b0, 32'h00000080);
        vecs[5]  = mk(1'b0, 1'b1, 6'd60, 3'd2, 32'hCAFEF00D, 1'b0, 32'h00000000);
        vecs[6]  = mk(1'b0, 1'b0, 6'd60, 3'd2, 32'h00000000, 1'b0, 32'hCAFEF00D);
        vecs[7]  = mk(1'b0, 1'b0, 6'd63, 3'd0, 32'h00000000, 1'b0, 32'hFFFFFFCA);
        vecs[8]  = mk(1'b0, 1'b0, 6'd61, 3'd2, 32'h00000000, 1'b1, 32'h00000000);
        vecs[9]  = mk(1'b0, 1'b0, 6'd63, 3'd1, 32'h00000000, 1'b1, 32'h00000000);
        vecs[10] = mk(1'b1, 1'b1, 6'd48, 3'd3, 32'hFFFFFFFF, 1'b1, 32'h00000000);
        vecs[11] = mk(1'b0, 1'b0, 6'd48, 3'd2, 32'h00000000, 1'b0, 32'h12345678);
        vecs[12] = mk(1'b1, 1'b0, 6'd48, 3'd1, 32'h00000000, 1'b0, 32'h00005678);
        vecs[13] = mk(1'b1, 1'b0, 6'd50, 3'd5, 32'h00000000, 1'b0, 32'h00001234);
        vecs[14] = mk(1'b0, 1'b0, 6'd62, 3'd1, 32'h00000000, 1'b0, 32'hFFFFCAFE);
        vecs[15] = mk(1'b1, 1'b0, 6'd62, 3'd5, 32'h00000000, 1'b0, 32'h0000CAFE);
        vecs[16] = mk(1'b0, 1'b1, 6'd0,  3'd2, 32'h0BADF00D, 1'b0, 32'h00000000);
        vecs[17] = mk(1'b1, 1'b0, 6'd8,  3'd7, 32'h00000000, 1'b1, 32'h00000000);
        vecs[18] = mk(1'b0, 1'b0, 6'd63, 3'd4, 32'h00000000, 1'b0, 32'h000000CA);

        drive_port(1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0);
        drive_port(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0);

        // Reset state
        @(negedge clk);
        check("rst_ack", {30'd0, bus.o_ack1, bus.o_ack0}, 32'd0);
        check("rst_err", {30'd0, bus.o_err1, bus.o_err0}, 32'd0);
        check("rst_en_we", {30'd0, bus.o_bank_en, bus.o_bank_we}, 32'd0);
        check("rst_rdata", bus.o_rdata, 32'd0);
        check("rst_addr_funct", {23'd0, bus.o_bank_funct, bus.o_bank_addr}, 32'd0);
        check("rst_wdata", bus.o_bank_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 19; i++) begin
            do_txn($sformatf("v%0d", i), vecs[i]);
        end

        // Reset asserted during the ACCESS cycle of a store to addr 0
        drive_port(1'b0, 1'b1, 1'b1, 6'd0, 3'd2, 32'h55AA55AA);
        @(negedge clk);
        check("mid_en_before", 32'(bus.o_bank_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_ack", {30'd0, bus.o_ack1, bus.o_ack0}, 32'd0);
        check("mid_en_we", {30'd0, bus.o_bank_en, bus.o_bank_we}, 32'd0);
        check("mid_rdata", bus.o_rdata, 32'd0);
        check("mid_addr_funct", {23'd0, bus.o_bank_funct, bus.o_bank_addr}, 32'd0);
        check("mid_wdata", bus.o_bank_wdata, 32'd0);
        drive_port(1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Contention: both ports hold requests for three transactions each
        drive_port(1'b0, 1'b1, 1'b0, 6'd48, 3'd2, 32'd0);
        drive_port(1'b1, 1'b1, 1'b0, 6'd32, 3'd4, 32'd0);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mke(1'b0, 1'b0, 32'h12345678));
            exp_q.push_back(mke(1'b1, 1'b0, 32'h00000080));
        end
        c0 = 0; c1 = 0; cyc = 0; last_ack = -1;
        while ((c0 < 3 || c1 < 3) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.o_ack0 || bus.o_ack1) begin
                if (last_ack >= 0) check("cont_spacing", 32'(cyc - last_ack), 32'd3);
                else               check("cont_first_latency", 32'(cyc), 32'd2);
                last_ack = cyc;
                if (bus.o_ack0) begin
                    c0++;
                    if (c0 == 3) bus.i_req0 = 1'b0;
                end
                if (bus.o_ack1) begin
                    c1++;
                    if (c1 == 3) bus.i_req1 = 1'b0;
                end
            end
        end
        check("cont_count0", 32'(c0), 32'd3);
        check("cont_count1", 32'(c1), 32'd3);
        drive_port(1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0);
        drive_port(1'b1, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0);
        @(negedge clk);

        // Aborted store must not have reached the bank
        do_txn("post_rst_read", mk(1'b0, 1'b0, 6'd0, 3'd2, 32'd0, 1'b0, 32'h0BADF00D));

        repeat (2) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/io_bank_arbiter.md
# io_bank_arbiter

Two-port arbiter and sequencer placed in front of the 64-byte memory-mapped output peripheral bank (LEDs, HEX, LCD, keypad rows). It shares the bank's single access port between the CPU load/store unit (port 0) and a secondary master such as a debug or display-refresh engine (port 1). It latches each winning transaction, checks that the access fits inside the bank, drives exactly one bank access cycle, and returns registered read data with a completion pulse. Round-robin arbitration means neither master can starve the other.

## Interface
- ADDR_W, 6, bank byte-address width (bank size 2^ADDR_W bytes)
- DATA_W, 32, data width of requesters and bank
- i_clk  in  1  single clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_req0 / i_req1  in  1  request from port 0 / port 1
- i_addr0 / i_addr1  in  ADDR_W  byte address
- i_we0 / i_we1  in  1  1 = store, 0 = load
- i_wdata0 / i_wdata1  in  DATA_W  store data, low bytes used
- i_funct0 / i_funct1  in  3  RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
- o_ack0 / o_ack1  out  1  one-cycle completion pulse
- o_err0 / o_err1  out  1  valid with ack; access rejected
- o_rdata  out  DATA_W  load result, valid during ack (shared by both ports)
- o_bank_en  out  1  bank enable (penable)
- o_bank_we  out  1  bank write (pwrite)
- o_bank_addr  out  ADDR_W  bank address
- o_bank_wdata  out  DATA_W  bank write data
- o_bank_funct  out  3  bank funct code
- i_bank_rdata  in  DATA_W  bank combinational read data (high-Z when en=0)

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset enters IDLE.
- **IDLE**
  - If any request is high, pick a winner.
  - With a single request, that port wins.
  - With both requests high, the port that did not win last time wins.
  - After reset, port 0 wins the first tie.
  - Latch the winner's addr, we, wdata and funct, and the winner ID, into internal registers. Go to ACCESS.
- **Legality check** (combinational on the latched payload):
  - Size is 1 for funct 0 and 4, 2 for funct 1 and 5, 4 for funct 2.
  - funct 3, 6 and 7 are illegal.
  - An access is illegal if its funct is illegal or addr + size > 2^ADDR_W. The check uses ADDR_W+1-bit arithmetic, so there is no wrap-around.
- **ACCESS** (exactly 1 cycle)
  - Legal access: o_bank_en=1; o_bank_we, o_bank_addr, o_bank_wdata and o_bank_funct driven from the latched payload. On the clock edge, capture i_bank_rdata into o_rdata; for stores, capture 0 instead.
  - Illegal access: o_bank_en stays 0, o_rdata is captured as 0, and the error flag is set. Go to DONE.
- **DONE** (exactly 1 cycle)
  - Pulse o_ackN for the latched winner, with o_errN = error flag.
  - Update the round-robin pointer to the winner.
  - Requests are ignored in this state. Go to IDLE.
- **Bank outputs**
  - o_bank_en is 0 in IDLE and DONE.
  - o_bank_addr, o_bank_wdata, o_bank_funct and o_bank_we show the latched payload at all times; they are zero after reset.
  - o_bank_we is gated: it is high only when o_bank_en=1.
- **Requester rules**
  - The payload must be valid only in the cycle the request is sampled in IDLE.
  - A requester holds req until it sees ack, and drops req or presents a new transaction in the cycle after ack.
  - If req drops after being granted, the transaction still completes and is still acked.
  - A non-granted request stays pending; no request is ever lost.

## Timing
- Reset values: state IDLE; o_ack0, o_ack1, o_err0, o_err1, o_bank_en and o_bank_we are 0; o_rdata, o_bank_addr, o_bank_wdata and o_bank_funct are 0; the round-robin pointer favours port 0.
- Request sampled in IDLE at edge N: ACCESS during cycle N+1, ack during N+2, IDLE again at N+3. Latency is 2 cycles from the sampling edge to ack; throughput is 1 access per 3 cycles.
- The bank store commits on the edge that ends the ACCESS cycle. A load issued in the next transaction sees the new value.
- o_rdata holds its value until the next ACCESS-cycle capture.
- An asynchronous reset in ACCESS or DONE aborts the transaction immediately:
  - no ack is issued;
  - the bank write is suppressed if i_rst is asserted before the edge.

## Test plan
- **Port 0 store, then load:** SW 0x12345678 to addr 48, then LW from addr 48 → o_bank_en high for exactly 1 cycle each; second ack has o_rdata=0x12345678 and err=0; ack arrives 2 cycles after sampling.
- **Byte sign extension:** port 1 SB 0x80 to addr 32, then LB → 0xFFFFFF80; LBU → 0x00000080.
- **Contention:** both ports hold req continuously for 6 transactions → grants alternate 0,1,0,1,0,1; every ack is 3 cycles apart.
- **Boundary:** LW at addr 61 and LH at addr 63 → err=1, rdata=0, o_bank_en never asserts. LW at 60 and LB at 63 → err=0.
- **Illegal funct:** funct 3 with we=1 → err=1 and the bank is unchanged (confirm by a later read).
- **Reset mid-operation:** assert i_rst during ACCESS of a SW to addr 0 → all outputs go to 0 at once; no ack; after release, port 0 wins a simultaneous request.
